food_placer: RTL
================

// Module: food_placer
// PURPOSE
//  Consumes the free-running coordinate stream from the random coordinate
//  generator and turns it into one validated food position per request.
//  - Samples a candidate from rand_x/rand_y.
//  - Range-checks the candidate against the playfield.
//  - Queries the snake-occupancy lookup; retries on a collision.
//  - Commits food_x/food_y, or reports failure after MAX_TRIES samples.
//  Sits between the generator and the game-control FSM.
// PARAMETERS
//  X_MIN      3    lowest legal food column (inclusive)
//  X_MAX      157  highest legal food column (inclusive)
//  Y_MIN      3    lowest legal food row (inclusive)
//  Y_MAX      117  highest legal food row (inclusive)
//  MAX_TRIES  32   candidate samples per request before fail; range 2..255
// PORTS
//  clock       in   1  system clock, all logic on posedge
//  reset       in   1  synchronous, active-high
//  rand_x      in   8  generator column, changes every cycle
//  rand_y      in   7  generator row, changes every cycle
//  place_req   in   1  1-cycle pulse: place new food (ignored while busy)
//  occ_req     out  1  1-cycle pulse: occupancy query strobe
//  occ_x       out  8  query column (held from occ_req until occ_ack)
//  occ_y       out  7  query row (held from occ_req until occ_ack)
//  occ_ack     in   1  query answered; occ_hit valid this cycle only
//  occ_hit     in   1  1 = cell occupied by snake
//  food_x      out  8  committed food column
//  food_y      out  7  committed food row
//  food_valid  out  1  food_x/food_y hold a live placement
//  busy        out  1  high in every state except IDLE
//  done        out  1  1-cycle pulse: placement committed
//  fail        out  1  1-cycle pulse: MAX_TRIES exhausted, no food placed
// BEHAVIOUR
//  Reset: state=IDLE; food_x=0, food_y=0, food_valid=0, occ_req=0,
//   occ_x=0, occ_y=0, done=0, fail=0, tries=0. A reset asserted in any
//   state aborts the request; the pending occ_ack is then ignored.
//  tries: 8-bit counter, incremented once per rejected candidate.
//  States:
//   IDLE:   on place_req -> food_valid<=0, tries<=0, go SAMPLE.
//   SAMPLE: latch cand={rand_x,rand_y} as seen this cycle.
//           In range (X_MIN<=x<=X_MAX and Y_MIN<=y<=Y_MAX) -> QUERY.
//           Out of range -> rejected candidate (see Reject).
//   QUERY:  occ_req=1 for exactly one cycle, occ_x/occ_y=cand -> WAIT.
//   WAIT:   hold occ_x/occ_y. On occ_ack: occ_hit=1 -> Reject;
//           occ_hit=0 -> COMMIT. occ_ack in the same cycle as occ_req is
//           not sampled; the earliest ack is 1 cycle after occ_req.
//   COMMIT: food_x/y<=cand, food_valid<=1, done=1 -> IDLE.
//   FAIL:   fail=1, food_valid stays 0 -> IDLE.
//  Reject: if tries==MAX_TRIES-1 -> FAIL, else tries++ and -> SAMPLE.
//  place_req in a non-IDLE state is dropped, not queued.
//  place_req in IDLE is accepted on the same cycle a done/fail pulse
//   deasserts.
//  Best-case latency: place_req to done = 4 cycles
//   (IDLE, SAMPLE, QUERY, WAIT with ack 1 cycle after occ_req, COMMIT).
//  Range compares are unsigned, at full input width.
//  rand_x=0 or rand_y=0 are ordinary out-of-range samples.
// TESTING
//  1 Reset mid-WAIT, then ack next cycle -> IDLE; no done or fail;
//    food_valid=0; occ_req stays 0.
//  2 rand=(50,40), place_req, occ_ack 1 cycle after occ_req with hit=0
//    -> occ_x=50, occ_y=40; done 4 cycles after place_req;
//    food=(50,40); food_valid=1.
//  3 rand_x=200 for 3 cycles, then (10,10) -> no occ_req for x=200;
//    single query at (10,10); commit (10,10).
//  4 occ_hit=1 on the first two queries, 0 on the third
//    -> 3 occ_req pulses, one done, tries=2 before commit.
//  5 occ_hit always 1, MAX_TRIES=4 -> 4 queries; fail pulse once;
//    food_valid=0; busy drops the cycle after fail.
//  6 place_req repeated during WAIT -> ignored; exactly one done.

Source files
------------

// File: rtl/food_placer_if.sv
// Signal bundle between the food placer, the coordinate generator, the
// snake-occupancy lookup and the game-control FSM.
// The slave view is the placer itself; the master view is everything around it.
interface food_placer_if;
  logic [7:0] rand_x;
  logic [6:0] rand_y;
  logic       place_req;
  logic       occ_req;
  logic [7:0] occ_x;
  logic [6:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;
  logic [7:0] food_x;
  logic [6:0] food_y;
  logic       food_valid;
  logic       busy;
  logic       done;
  logic       fail;

  modport master (
    output rand_x, rand_y, place_req, occ_ack, occ_hit,
    input  occ_req, occ_x, occ_y, food_x, food_y, food_valid, busy, done, fail
  );

  modport slave (
    input  rand_x, rand_y, place_req, occ_ack, occ_hit,
    output occ_req, occ_x, occ_y, food_x, food_y, food_valid, busy, done, fail
  );
endinterface

// File: rtl/food_placer.sv
// Food placer: turns the free-running generator coordinates into one
// validated food position per request. Each candidate is range-checked
// against the playfield, then checked against the snake-occupancy lookup.
// Rejected candidates are retried until MAX_TRIES samples have been used,
// after which a fail pulse is reported instead of a placement.
// MAX_TRIES must lie in 2..255 so the last-try compare fits the 8-bit counter.
module food_placer #(
  parameter int unsigned X_MIN     = 3,
  parameter int unsigned X_MAX     = 157,
  parameter int unsigned Y_MIN     = 3,
  parameter int unsigned Y_MAX     = 117,
  parameter int unsigned MAX_TRIES = 32
) (
  input  logic         clock,
  input  logic         reset,
  food_placer_if.slave bus
);

  // Playfield bounds narrowed to the input widths so compares stay unsigned
  // at full input width.
  localparam logic [7:0] X_LO     = 8'(X_MIN);
  localparam logic [7:0] X_HI     = 8'(X_MAX);
  localparam logic [6:0] Y_LO     = 7'(Y_MIN);
  localparam logic [6:0] Y_HI     = 7'(Y_MAX);
  localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_QUERY,
    S_WAIT,
    S_COMMIT,
    S_FAIL
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cand_x_q, cand_x_d;
  logic [6:0] cand_y_q, cand_y_d;
  logic [7:0] tries_q, tries_d;
  logic [7:0] food_x_q, food_x_d;
  logic [6:0] food_y_q, food_y_d;
  logic       food_valid_q, food_valid_d;

  logic       rand_in_range;
  logic       last_try;

  // Candidate range test on the raw generator outputs and final-try detection.
  always_comb begin
    rand_in_range = (bus.rand_x >= X_LO) && (bus.rand_x <= X_HI) &&
                    (bus.rand_y >= Y_LO) && (bus.rand_y <= Y_HI);
    last_try      = (tries_q == LAST_TRY);
  end

  // Next-state logic: sample, query, await the lookup answer, commit or retry.
  always_comb begin
    state_d      = state_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    tries_d      = tries_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.place_req) begin
          food_valid_d = 1'b0;
          tries_d      = 8'd0;
          state_d      = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        cand_x_d = bus.rand_x;
        cand_y_d = bus.rand_y;
        if (rand_in_range) begin
          state_d = S_QUERY;
        end else if (last_try) begin
          state_d = S_FAIL;
        end else begin
          tries_d = tries_q + 8'd1;
          state_d = S_SAMPLE;
        end
      end

      S_QUERY: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.occ_ack) begin
          if (!bus.occ_hit) begin
            state_d = S_COMMIT;
          end else if (last_try) begin
            state_d = S_FAIL;
          end else begin
            tries_d = tries_q + 8'd1;
            state_d = S_SAMPLE;
          end
        end
      end

      S_COMMIT: begin
        food_x_d     = cand_x_q;
        food_y_d     = cand_y_q;
        food_valid_d = 1'b1;
        state_d      = S_IDLE;
      end

      S_FAIL: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any outstanding query.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cand_x_q     <= 8'd0;
      cand_y_q     <= 7'd0;
      tries_q      <= 8'd0;
      food_x_q     <= 8'd0;
      food_y_q     <= 7'd0;
      food_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      tries_q      <= tries_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
    end
  end

  // Moore outputs; the query coordinates are the latched candidate, which
  // cannot change between the query strobe and the answer.
  always_comb begin
    bus.occ_req    = (state_q == S_QUERY);
    bus.occ_x      = cand_x_q;
    bus.occ_y      = cand_y_q;
    bus.done       = (state_q == S_COMMIT);
    bus.fail       = (state_q == S_FAIL);
    bus.busy       = (state_q != S_IDLE);
    bus.food_x     = food_x_q;
    bus.food_y     = food_y_q;
    bus.food_valid = food_valid_q;
  end

endmodule
